// File: rtl/pul_profile_pkg.sv
// Shared types and width constants for the pulse-profile feeder.
package pul_profile_pkg;

  // Generator sequencing: ramp up, ramp down, then wait for the consumer to empty the FIFO.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_DECEL = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int W_DEFAULT = 32;  // period word width
  localparam int STEP_W    = 32;  // total pulse count width
  localparam int IDX_W     = 16;  // accel_end / decel_begin index width

endpackage

// File: rtl/pul_profile_feeder_if.sv
// Bus between the pulse controller (master) and the profile feeder (slave):
// move configuration, abort, and the read/pul_value word stream with status flags.
interface pul_profile_feeder_if
  import pul_profile_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic              cfg_load;
  logic              abort;
  logic [STEP_W-1:0] step;
  logic [IDX_W-1:0]  accel_end;
  logic [IDX_W-1:0]  decel_begin;
  logic [W-1:0]      period_start;
  logic [W-1:0]      period_min;
  logic [W-1:0]      period_delta;
  logic              read;
  logic [W-1:0]      pul_value;
  logic              empty;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              cfg_err;

  modport master (
    output cfg_load, abort, step, accel_end, decel_begin,
           period_start, period_min, period_delta, read,
    input  pul_value, empty, busy, done, underrun, cfg_err
  );

  modport slave (
    input  cfg_load, abort, step, accel_end, decel_begin,
           period_start, period_min, period_delta, read,
    output pul_value, empty, busy, done, underrun, cfg_err
  );
endinterface

// File: rtl/pul_fifo_sync.sv
// Synchronous FIFO, DEPTH x W, with a registered read port (data appears the
// cycle after a pop) and a flush that clears pointers but keeps the last read word.
module pul_fifo_sync #(
  parameter  int DEPTH = 8,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_rdata;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_rdata;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign w_rd = i_pop && !o_empty && !i_flush;
  assign w_wr = i_push && !i_flush && (!o_full || w_rd);

  // Storage array kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer/occupancy bookkeeping and the registered read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rdata  <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pul_profile_feeder.sv
// Expands a trapezoidal move into acceleration and deceleration period words
// and feeds them to the pulse controller through a small FIFO. The plateau is
// not streamed; the controller keeps using the last acceleration word.
module pul_profile_feeder
  import pul_profile_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  pul_profile_feeder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t            r_state;
  logic [IDX_W-1:0]  r_accel_end;
  logic [STEP_W-1:0] r_dec_cnt;
  logic [W-1:0]      r_start;
  logic [W-1:0]      r_min;
  logic [W-1:0]      r_delta;
  logic [IDX_W-1:0]  r_k;
  logic [STEP_W-1:0] r_j;
  logic [W-1:0]      r_cur;
  logic              r_done;
  logic              r_underrun;
  logic              r_cfg_err;

  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [W-1:0]      w_rdata;
  logic              w_cfg_bad;
  logic              w_last_accel;
  logic              w_last_decel;

  // Step down by d but never below lo; the extra top bit catches a wrap past zero.
  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] d,
                                           input logic [W-1:0] lo);
    logic [W:0] diff;
    diff = {1'b0, a} - {1'b0, d};
    if (diff[W] || (diff < {1'b0, lo})) return lo;
    return diff[W-1:0];
  endfunction

  // Step up by d but never above hi; computed one bit wider so overflow cannot wrap.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] d,
                                           input logic [W-1:0] hi);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, d};
    if (sum > {1'b0, hi}) return hi;
    return sum[W-1:0];
  endfunction

  assign w_cfg_bad = (bus.decel_begin < bus.accel_end) ||
                     (STEP_W'(bus.decel_begin) > bus.step) ||
                     (bus.period_min > bus.period_start);

  // Counters are only compared while their phase is active, so the terminal count is >= 1.
  assign w_last_accel = (r_k == r_accel_end - IDX_W'(1));
  assign w_last_decel = (r_j == r_dec_cnt - STEP_W'(1));

  assign w_pop  = bus.read && !w_empty && !bus.abort;
  assign w_push = ((r_state == ST_ACCEL) || (r_state == ST_DECEL)) && !bus.abort &&
                  (!w_full || w_pop);

  pul_fifo_sync #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.abort),
    .i_push  (w_push),
    .i_wdata (r_cur),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign bus.pul_value = w_rdata;
  assign bus.empty     = w_empty;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.underrun  = r_underrun;
  assign bus.cfg_err   = r_cfg_err;

  // Move sequencer: latches the configuration, walks the ramps with r_cur as the
  // next word to push, and signals completion when the consumer drains the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_accel_end <= '0;
      r_dec_cnt   <= '0;
      r_start     <= '0;
      r_min       <= '0;
      r_delta     <= '0;
      r_k         <= '0;
      r_j         <= '0;
      r_cur       <= '0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.read && w_empty) r_underrun <= 1'b1;

      if (bus.abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.cfg_load) begin
              r_underrun <= 1'b0;
              if (w_cfg_bad) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_cfg_err   <= 1'b0;
                r_accel_end <= bus.accel_end;
                r_dec_cnt   <= bus.step - STEP_W'(bus.decel_begin);
                r_start     <= bus.period_start;
                r_min       <= bus.period_min;
                r_delta     <= bus.period_delta;
                r_k         <= '0;
                r_j         <= '0;
                if (bus.accel_end != '0) begin
                  r_cur   <= bus.period_start;
                  r_state <= ST_ACCEL;
                end else begin
                  // No ramp-up: the plateau is period_start itself.
                  r_cur   <= sat_add(bus.period_start, bus.period_delta, bus.period_start);
                  r_state <= (bus.step == STEP_W'(bus.decel_begin)) ? ST_DRAIN : ST_DECEL;
                end
              end
            end
          end
          ST_ACCEL: begin
            if (w_push) begin
              r_k <= r_k + IDX_W'(1);
              if (w_last_accel) begin
                // r_cur is the plateau word; the first decel word is one delta above it.
                r_cur   <= sat_add(r_cur, r_delta, r_start);
                r_state <= (r_dec_cnt == '0) ? ST_DRAIN : ST_DECEL;
              end else begin
                r_cur <= sat_sub(r_cur, r_delta, r_min);
              end
            end
          end
          ST_DECEL: begin
            if (w_push) begin
              r_j   <= r_j + STEP_W'(1);
              r_cur <= sat_add(r_cur, r_delta, r_start);
              if (w_last_decel) r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (w_empty || (w_pop && (w_count == CW'(1)))) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pul_profile_feeder.sv
// Directed bench for pul_profile_feeder: underrun/abort, nominal move,
// back-pressure, degenerate and invalid configurations, and async reset.
module tb_pul_profile_feeder;
  import pul_profile_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          failures;
  logic [31:0] exp_seq [16];

  pul_profile_feeder_if #(.W(W)) bus ();

  pul_profile_feeder #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [31:0] stp, input logic [15:0] ae, input logic [15:0] db,
                         input logic [31:0] ps, input logic [31:0] pm, input logic [31:0] pd);
    bus.step         = stp;
    bus.accel_end    = ae;
    bus.decel_begin  = db;
    bus.period_start = ps;
    bus.period_min   = pm;
    bus.period_delta = pd;
  endtask

  // Pulses cfg_load for one cycle; returns at the negedge after the sampling edge.
  task automatic load_pulse();
    bus.cfg_load = 1'b1;
    cyc(1);
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_seq  = '{1000, 900, 800, 700, 600, 500, 400, 400,
                 500, 600, 700, 800, 900, 1000, 1000, 1000};
    bus.cfg_load = 1'b0;
    bus.abort    = 1'b0;
    bus.read     = 1'b0;
    set_cfg(32'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);

    // Reset state
    rst_n = 1'b0;
    cyc(2);
    chk("rst_pul_value", bus.pul_value, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    rst_n = 1'b1;
    cyc(1);

    // Underrun: read lands while the FIFO is still empty, then abort after 5 pops
    set_cfg(32'd28, 16'd8, 16'd20, 32'd1000, 32'd400, 32'd100);
    load_pulse();
    chk("ur_busy_rise", bus.busy, 1);
    chk("ur_empty_cycle1", bus.empty, 1);
    bus.read = 1'b1;
    cyc(1);
    bus.read = 1'b0;
    chk("ur_flag", bus.underrun, 1);
    chk("ur_value_hold", bus.pul_value, 0);
    chk("ur_empty_fall", bus.empty, 0);
    for (int i = 0; i < 5; i++) begin
      bus.read = 1'b1;
      cyc(1);
      bus.read = 1'b0;
      chk($sformatf("ur_word%0d", i), bus.pul_value, exp_seq[i]);
      cyc(1);
    end
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("abort_empty", bus.empty, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_value_hold", bus.pul_value, 600);
    chk("abort_underrun_sticky", bus.underrun, 1);
    cyc(1);
    chk("abort_done_later", bus.done, 0);
    chk("abort_empty_later", bus.empty, 1);

    // Nominal move, read every 3 cycles
    load_pulse();
    chk("nom_underrun_clr", bus.underrun, 0);
    chk("nom_busy_rise", bus.busy, 1);
    chk("nom_empty_cycle1", bus.empty, 1);
    cyc(1);
    chk("nom_empty_cycle2", bus.empty, 0);
    for (int i = 0; i < 16; i++) begin
      bus.read = 1'b1;
      cyc(1);
      bus.read = 1'b0;
      chk($sformatf("nom_word%0d", i), bus.pul_value, exp_seq[i]);
      chk($sformatf("nom_done%0d", i), bus.done, (i == 15) ? 1 : 0);
      chk($sformatf("nom_busy%0d", i), bus.busy, (i == 15) ? 0 : 1);
      cyc(1);
      chk($sformatf("nom_done_gap%0d", i), bus.done, 0);
      cyc(1);
    end
    chk("nom_underrun_end", bus.underrun, 0);
    chk("nom_empty_end", bus.empty, 1);

    // Back-pressure: no reads for 50 cycles, then read every cycle
    load_pulse();
    cyc(50);
    chk("bp_fifo_full", dut.u_fifo.r_count, DEPTH);
    chk("bp_busy", bus.busy, 1);
    chk("bp_done_idle", bus.done, 0);
    bus.read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      chk($sformatf("bp_word%0d", i), bus.pul_value, exp_seq[i]);
      chk($sformatf("bp_done%0d", i), bus.done, (i == 15) ? 1 : 0);
    end
    bus.read = 1'b0;
    chk("bp_busy_end", bus.busy, 0);
    chk("bp_underrun", bus.underrun, 0);

    // Zero-word move: accel_end=0, decel_begin=step=5
    set_cfg(32'd5, 16'd0, 16'd5, 32'd1000, 32'd400, 32'd100);
    load_pulse();
    chk("zero_busy", bus.busy, 1);
    chk("zero_empty1", bus.empty, 1);
    chk("zero_done1", bus.done, 0);
    cyc(1);
    chk("zero_done2", bus.done, 1);
    chk("zero_busy2", bus.busy, 0);
    chk("zero_empty2", bus.empty, 1);
    cyc(1);
    chk("zero_done3", bus.done, 0);

    // Invalid configuration: decel_begin < accel_end
    set_cfg(32'd28, 16'd4, 16'd3, 32'd1000, 32'd400, 32'd100);
    load_pulse();
    chk("err_flag", bus.cfg_err, 1);
    chk("err_busy", bus.busy, 0);
    cyc(1);
    chk("err_busy_later", bus.busy, 0);
    chk("err_flag_sticky", bus.cfg_err, 1);

    // Asynchronous reset in the middle of deceleration
    set_cfg(32'd28, 16'd8, 16'd20, 32'd1000, 32'd400, 32'd100);
    load_pulse();
    chk("mid_cfg_err_clr", bus.cfg_err, 0);
    cyc(1);
    bus.read = 1'b1;
    cyc(12);
    chk("mid_word11", bus.pul_value, exp_seq[11]);
    chk("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_pul_value", bus.pul_value, 0);
    chk("mrst_empty", bus.empty, 1);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_underrun", bus.underrun, 0);
    chk("mrst_cfg_err", bus.cfg_err, 0);
    bus.read = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pul_profile_feeder.md
# pul_profile_feeder

Supplies the per-step pulse-period words that the motor pulse controller pulls with its `read` strobe and consumes on `pul_value`. It replaces the PS/DDR source for trapezoidal moves. A configured move is expanded on chip into the acceleration and deceleration period sequences. These words are buffered in a small FIFO and returned one word per `read`. The plateau is never streamed: the controller holds the last acceleration word through its constant-speed phase.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in words (power of two, ≥2).
- `W`, 32: period word width.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. This is decided.
- `cfg_load`, in, 1: one-cycle pulse; latches configuration and starts a move.
- `abort`, in, 1: one-cycle pulse; flushes the FIFO and returns to IDLE.
- `step`, in, 32: total pulses of the move.
- `accel_end`, in, 16: pulse index where acceleration ends.
- `decel_begin`, in, 16: pulse index where deceleration starts.
- `period_start`, in, W: slowest period (first word, decel cap).
- `period_min`, in, W: fastest permitted period.
- `period_delta`, in, W: period change per word.
- `read`, in, 1: pop request from the consumer.
- `pul_value`, out, W: word returned by the last accepted `read`.
- `empty`, out, 1: FIFO empty.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse when the final word is popped.
- `underrun`, out, 1: sticky flag; set by a `read` while empty.
- `cfg_err`, out, 1: sticky flag; set by an invalid configuration.

## Operation
- States: IDLE, ACCEL, DECEL, DRAIN.
- IDLE → ACCEL on `cfg_load`. The configuration is registered, `underrun` and `cfg_err` are cleared, and the generator index k=0.
- Before leaving IDLE, the configuration is checked. If `decel_begin < accel_end`, or `decel_begin > step`, or `period_min > period_start`, then `cfg_err` is set and the block stays in IDLE.
- ACCEL: generates `accel_end` words. Word k = max(period_start − k·period_delta, period_min). Use a running register with a saturating subtract. The comparison is done at W+1 bits, so there is no wrap below `period_min`.
- The last ACCEL word is latched as `p_plat`. If `accel_end`=0, then `p_plat` = `period_start` and ACCEL is skipped.
- ACCEL → DECEL once k = `accel_end`.
- DECEL: generates `step − decel_begin` words. Word j = min(p_plat + (j+1)·period_delta, period_start). Use a running register with a saturating add, compared at W+1 bits. If `decel_begin` = `step`, DECEL is skipped.
- DECEL → DRAIN after the last word is pushed.
- DRAIN → IDLE when the FIFO is empty after the final pop; `done` pulses in that cycle.
- Generation rule: at most one word is pushed per cycle, and only while the FIFO is not full. Generation stalls without loss when the FIFO is full.
- Total words per move: `accel_end` + `step` − `decel_begin`.
- `read` handling:
  - `read` with the FIFO not empty: pop, and `pul_value` takes the popped word on the next edge.
  - `read` with the FIFO empty: `underrun` is set, `pul_value` holds, and no pop occurs.
- Simultaneous push and pop on a full FIFO: both are accepted.
- Simultaneous push and pop on an empty FIFO: only the push happens, and `underrun` is set.
- `abort` takes priority over `cfg_load` and over generation. It clears the FIFO and returns to IDLE. `pul_value` holds its value, and no `done` is issued.
- `cfg_load` while `busy`: ignored.

## Timing
- Reset values: `pul_value`=0, `empty`=1, `busy`=0, `done`=0, `underrun`=0, `cfg_err`=0, state=IDLE, FIFO pointers=0.
- Latency from `cfg_load` to the first word in the FIFO: 2 cycles. `empty` falls in cycle 2 after `cfg_load`.
- Read-to-data latency: 1 cycle (registered output, not first-word-fall-through).
- `busy` rises 1 cycle after `cfg_load`.
- `done` and the fall of `busy` occur on the edge that processes the final pop.
- Reset mid-move: all state is discarded immediately (asynchronous reset).

## Structure
- The package `pul_profile_pkg` holds:
  - the state enum (IDLE/ACCEL/DECEL/DRAIN);
  - localparams for the W default and the 16/32-bit count widths.
- Sub-module `pul_fifo_sync` is a synchronous FIFO, `DEPTH`×W, with a registered read port and full/empty flags.
- The generator FSM and the saturating arithmetic live in the top level.

## Test plan
- Nominal move, with start=1000, min=400, delta=100, accel_end=8, decel_begin=20, step=28, and `read` issued every 3 cycles:
  - words returned are 1000,900,800,700,600,500,400,400, then 500,600,700,800,900,1000,1000,1000;
  - `done` pulses after the 16th pop;
  - `underrun` stays 0.
- Back-pressure, with the same configuration and no `read` for 50 cycles:
  - FIFO fills to `DEPTH`, and generation stalls;
  - when reads resume, the full sequence returns unchanged.
- Edge configuration, accel_end=0, decel_begin=step=5: exactly 0 words are produced, and `done` pulses once DRAIN sees the FIFO empty. Also load decel_begin=3 with accel_end=4: `cfg_err`=1 and `busy` stays 0.
- Underrun: `read` two cycles after `cfg_load`:
  - `underrun`=1 and `pul_value` holds 0;
  - a later `read` returns 1000.
- Abort and reset:
  - `abort` after 5 pops: the FIFO is empty next cycle, `busy`=0, and there is no `done`;
  - `rst_n` low mid-DECEL: all outputs take their reset values immediately.
